// File: rtl/adiabatic_clock_sequencer_if.sv
// Launch/result handshake and per-phase DAC code bundle of the adiabatic clock sequencer.
interface adiabatic_clock_sequencer_if #(
  parameter int unsigned DAC_W = 6
);
  logic               en;
  logic               op_valid;
  logic               op_ready;
  logic               res_valid;
  logic               busy;
  logic               qtick;
  logic [7:0]         ph_state;
  logic [4*DAC_W-1:0] pos_code;
  logic [4*DAC_W-1:0] neg_code;

  modport master (
    output en, op_valid,
    input  op_ready, res_valid, busy, qtick, ph_state, pos_code, neg_code
  );

  modport slave (
    input  en, op_valid,
    output op_ready, res_valid, busy, qtick, ph_state, pos_code, neg_code
  );
endinterface

// File: rtl/adiabatic_clock_sequencer.sv
// 4-phase adiabatic power-clock sequencer: trapezoidal DAC ramp codes per phase, one operand
// launch slot per period, fixed-latency result strobe and graceful start-up / wind-down.
module adiabatic_clock_sequencer #(
  parameter int unsigned RAMP_CYC = 4,
  parameter int unsigned DAC_W    = 6,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  adiabatic_clock_sequencer_if.slave  bus
);

  localparam int unsigned QW = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam int unsigned PW = QW + DAC_W + 1;
  localparam int unsigned CW = 4 * DAC_W;

  localparam logic [QW-1:0]    LAST = QW'(RAMP_CYC - 1);
  localparam logic [DAC_W-1:0] MAXC = '1;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_RISE = 2'b01;
  localparam logic [1:0] PH_HOLD = 2'b10;
  localparam logic [1:0] PH_FALL = 2'b11;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    WIND  = 2'd3
  } fsm_t;

  fsm_t             fsm_q, fsm_n;
  logic [1:0]       q_q, q_n;
  logic [QW-1:0]    qcnt_q, qcnt_n;
  logic [3:0]       active_q, active_n;
  logic [DEPTH:0]   inflight_q, inflight_n;
  logic             slot_q, slot_n;
  logic             res_valid_q, res_valid_n;
  logic             busy_q, busy_n;
  logic             qtick_q, qtick_n;
  logic [7:0]       ph_q, ph_n;
  logic [CW-1:0]    pos_q, pos_n;

  logic             tick_c;
  logic             accept_c;
  logic             rise_ok_c;
  logic [1:0]       nom_c [4];
  logic [PW-1:0]    prod_c;
  logic [DAC_W-1:0] ramp_c;

  // The launch slot is a registered window qualified by the live run request,
  // so dropping en in the slot cycle itself refuses the operand.
  assign bus.op_ready  = slot_q & bus.en;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
  assign bus.qtick     = qtick_q;
  assign bus.ph_state  = ph_q;
  assign bus.pos_code  = pos_q;
  assign bus.neg_code  = ~pos_q;

  // Next-state: sequencing FSM, quarter timing, phase activity and in-flight tracking
  always_comb begin
    fsm_n      = fsm_q;
    q_n        = q_q;
    qcnt_n     = qcnt_q;
    active_n   = active_q;
    inflight_n = inflight_q;
    rise_ok_c  = 1'b0;
    tick_c     = (fsm_q != HALT) && (qcnt_q == LAST);
    accept_c   = bus.op_valid && slot_q && bus.en;

    if (tick_c) begin
      inflight_n = {inflight_q[DEPTH-1:0], accept_c};
    end

    case (fsm_q)
      HALT:    if (bus.en) fsm_n = RUN;
      RUN:     if (!bus.en) fsm_n = FLUSH;
      FLUSH: begin
        if (bus.en) begin
          fsm_n = RUN;
        end else if (inflight_n == '0) begin
          fsm_n = WIND;
        end
      end
      WIND:    fsm_n = WIND;
      default: fsm_n = HALT;
    endcase

    if (fsm_q != HALT) begin
      if (tick_c) begin
        qcnt_n = '0;
        q_n    = q_q + 2'd1;
      end else begin
        qcnt_n = qcnt_q + QW'(1);
      end
    end

    rise_ok_c = (fsm_n == RUN) || (fsm_n == FLUSH);

    // Nominal phase state encodes directly as ((q - p) + 1) mod 4
    for (int p = 0; p < 4; p++) begin
      nom_c[p] = 2'(q_n - 2'(p) + 2'd1);
      if (nom_c[p] == PH_IDLE) begin
        active_n[p] = 1'b0;
      end else if ((nom_c[p] == PH_RISE) && (qcnt_n == '0) && rise_ok_c) begin
        active_n[p] = 1'b1;
      end
    end

    if ((fsm_q == WIND) && (active_n == '0)) begin
      fsm_n  = HALT;
      q_n    = '0;
      qcnt_n = '0;
    end
  end

  // Registered outputs are derived from next-state so codes move together with phase state
  always_comb begin
    prod_c      = (PW'(qcnt_n) + PW'(1)) * PW'(MAXC);
    ramp_c      = DAC_W'(prod_c / PW'(RAMP_CYC));
    ph_n        = '0;
    pos_n       = '0;
    qtick_n     = (fsm_n != HALT) && (qcnt_n == LAST);
    slot_n      = (fsm_n == RUN) && (q_n == 2'd3) && (qcnt_n == LAST);
    res_valid_n = qtick_n && inflight_n[DEPTH];
    busy_n      = (fsm_n != HALT) || (|inflight_n);

    for (int p = 0; p < 4; p++) begin
      if (active_n[p]) begin
        ph_n[2*p +: 2] = nom_c[p];
        case (nom_c[p])
          PH_RISE: pos_n[p*DAC_W +: DAC_W] = ramp_c;
          PH_HOLD: pos_n[p*DAC_W +: DAC_W] = MAXC;
          PH_FALL: pos_n[p*DAC_W +: DAC_W] = MAXC - ramp_c;
          default: pos_n[p*DAC_W +: DAC_W] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= HALT;
      q_q         <= '0;
      qcnt_q      <= '0;
      active_q    <= '0;
      inflight_q  <= '0;
      slot_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      qtick_q     <= 1'b0;
      ph_q        <= '0;
      pos_q       <= '0;
    end else begin
      fsm_q       <= fsm_n;
      q_q         <= q_n;
      qcnt_q      <= qcnt_n;
      active_q    <= active_n;
      inflight_q  <= inflight_n;
      slot_q      <= slot_n;
      res_valid_q <= res_valid_n;
      busy_q      <= busy_n;
      qtick_q     <= qtick_n;
      ph_q        <= ph_n;
      pos_q       <= pos_n;
    end
  end

endmodule

// File: tb/tb_adiabatic_clock_sequencer.sv
// Bench for adiabatic_clock_sequencer: per-scenario tasks plus a result-latency scoreboard.
module tb_adiabatic_clock_sequencer;

  localparam int unsigned RAMP_CYC = 4;
  localparam int unsigned DAC_W    = 6;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LAT      = (DEPTH + 1) * RAMP_CYC;

  logic clk = 1'b0;
  logic rst;

  int unsigned total    = 0;
  int unsigned bad      = 0;
  int unsigned cyc      = 0;
  int unsigned res_seen = 0;
  int unsigned exp_cyc;
  int unsigned exp_q [$];

  logic [DAC_W-1:0] p0_tab [16] = '{6'd15, 6'd31, 6'd47, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63,
                                    6'd48, 6'd32, 6'd16, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0};
  logic [1:0]       st_tab [16] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                    2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};

  adiabatic_clock_sequencer_if #(.DAC_W(DAC_W)) bus ();

  adiabatic_clock_sequencer #(
    .RAMP_CYC(RAMP_CYC),
    .DAC_W   (DAC_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted operand expects one res_valid exactly LAT cycles later
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.res_valid) begin
        total++;
        res_seen++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL res_unexpected: pulse at cycle %0d, none pending", cyc);
        end else begin
          exp_cyc = exp_q.pop_front();
          if (cyc !== exp_cyc) begin
            bad++;
            $display("FAIL res_latency: pulse at cycle %0d, want %0d", cyc, exp_cyc);
          end
        end
      end
      if (bus.op_valid && bus.op_ready) exp_q.push_back(cyc + LAT);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.op_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.op_valid = 1'b0;
    tick();
    tick();
    total++; if (bus.op_ready !== 1'b0) begin bad++; $display("FAIL rst_op_ready got=%b want=0", bus.op_ready); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", bus.res_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.qtick !== 1'b0) begin bad++; $display("FAIL rst_qtick got=%b want=0", bus.qtick); end
    total++; if (bus.ph_state !== 8'h00) begin bad++; $display("FAIL rst_ph_state got=%h want=00", bus.ph_state); end
    total++; if (bus.pos_code !== 24'h000000) begin bad++; $display("FAIL rst_pos got=%h want=000000", bus.pos_code); end
    total++; if (bus.neg_code !== 24'hffffff) begin bad++; $display("FAIL rst_neg got=%h want=ffffff", bus.neg_code); end
    rst = 1'b0;
    tick();
    total++; if (bus.ph_state !== 8'h01) begin bad++; $display("FAIL start_ph_state got=%h want=01", bus.ph_state); end
    total++; if (bus.pos_code !== 24'd15) begin bad++; $display("FAIL start_pos got=%h want=00000f", bus.pos_code); end
    total++; if (bus.neg_code !== 24'hffffff - 24'd15) begin bad++; $display("FAIL start_neg got=%h want=fffff0", bus.neg_code); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", bus.busy); end
  endtask

  task automatic test_free_run();
    logic [DAC_W-1:0] want1;
    logic [1:0]       wst1;
    start_run();
    for (int c = 0; c < 32; c++) begin
      want1 = (c < 4) ? 6'd0 : p0_tab[(c - 4) % 16];
      wst1  = (c < 4) ? 2'd0 : st_tab[(c - 4) % 16];
      total++; if (bus.pos_code[DAC_W-1:0] !== p0_tab[c % 16]) begin bad++; $display("FAIL free_p0_code c=%0d got=%0d want=%0d", c, bus.pos_code[DAC_W-1:0], p0_tab[c % 16]); end
      total++; if (bus.ph_state[1:0] !== st_tab[c % 16]) begin bad++; $display("FAIL free_p0_state c=%0d got=%0d want=%0d", c, bus.ph_state[1:0], st_tab[c % 16]); end
      total++; if (bus.pos_code[2*DAC_W-1:DAC_W] !== want1) begin bad++; $display("FAIL free_p1_code c=%0d got=%0d want=%0d", c, bus.pos_code[2*DAC_W-1:DAC_W], want1); end
      total++; if (bus.ph_state[3:2] !== wst1) begin bad++; $display("FAIL free_p1_state c=%0d got=%0d want=%0d", c, bus.ph_state[3:2], wst1); end
      total++; if (bus.neg_code !== ~bus.pos_code) begin bad++; $display("FAIL free_neg c=%0d got=%h want=%h", c, bus.neg_code, ~bus.pos_code); end
      total++; if (bus.qtick !== (c % 4 == 3)) begin bad++; $display("FAIL free_qtick c=%0d got=%b want=%b", c, bus.qtick, (c % 4 == 3)); end
      total++; if (bus.op_ready !== (c % 16 == 15)) begin bad++; $display("FAIL free_op_ready c=%0d got=%b want=%b", c, bus.op_ready, (c % 16 == 15)); end
      tick();
    end
  endtask

  task automatic test_launch();
    start_run();
    res_seen = 0;
    bus.op_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      total++; if (bus.op_ready !== (c % 16 == 15)) begin bad++; $display("FAIL launch_op_ready c=%0d got=%b want=%b", c, bus.op_ready, (c % 16 == 15)); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL launch_busy c=%0d got=%b want=1", c, bus.busy); end
      tick();
    end
    bus.op_valid = 1'b0;
    for (int c = 0; c < 24; c++) tick();
    total++; if (res_seen !== 4) begin bad++; $display("FAIL launch_res_count got=%0d want=4", res_seen); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL launch_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_flush_wind();
    int  halt_c;
    bit  done;
    start_run();
    res_seen = 0;
    bus.op_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 16) bus.op_valid = 1'b0;
      tick();
    end
    bus.en = 1'b0;
    halt_c = 0;
    done = 1'b0;
    for (int c = 20; c < 100; c++) begin
      if (!bus.busy) begin
        halt_c = c;
        done = 1'b1;
        break;
      end
      if (c <= 35) begin
        total++; if (bus.qtick !== (c % 4 == 3)) begin bad++; $display("FAIL flush_qtick c=%0d got=%b want=%b", c, bus.qtick, (c % 4 == 3)); end
      end
      tick();
    end
    total++; if (!done) begin bad++; $display("FAIL wind_timeout: busy still %b after 100 cycles, want 0", bus.busy); end
    total++; if (done && (halt_c < 44 || halt_c > 48)) begin bad++; $display("FAIL wind_halt_cycle got=%0d want=44..48", halt_c); end
    total++; if (res_seen !== 1) begin bad++; $display("FAIL flush_res_count got=%0d want=1", res_seen); end
    total++; if (bus.ph_state !== 8'h00) begin bad++; $display("FAIL halt_ph_state got=%h want=00", bus.ph_state); end
    total++; if (bus.pos_code !== 24'h000000) begin bad++; $display("FAIL halt_pos got=%h want=000000", bus.pos_code); end
    total++; if (bus.neg_code !== 24'hffffff) begin bad++; $display("FAIL halt_neg got=%h want=ffffff", bus.neg_code); end
    for (int c = 0; c < 8; c++) begin
      tick();
      total++; if (bus.busy !== 1'b0 || bus.qtick !== 1'b0) begin bad++; $display("FAIL halt_idle c=%0d busy=%b qtick=%b want 0 0", c, bus.busy, bus.qtick); end
    end
  endtask

  task automatic test_en_toggle();
    start_run();
    res_seen = 0;
    for (int c = 0; c < 80; c++) begin
      bus.op_valid = (c < 16) || (c >= 40 && c < 48);
      bus.en = !(c >= 18 && c <= 20);
      total++; if (bus.pos_code[DAC_W-1:0] !== p0_tab[c % 16]) begin bad++; $display("FAIL toggle_p0_code c=%0d got=%0d want=%0d", c, bus.pos_code[DAC_W-1:0], p0_tab[c % 16]); end
      total++; if (bus.qtick !== (c % 4 == 3)) begin bad++; $display("FAIL toggle_qtick c=%0d got=%b want=%b", c, bus.qtick, (c % 4 == 3)); end
      total++; if (bus.op_ready !== (bus.en && (c % 16 == 15))) begin bad++; $display("FAIL toggle_op_ready c=%0d got=%b want=%b", c, bus.op_ready, (bus.en && (c % 16 == 15))); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL toggle_busy c=%0d got=%b want=1", c, bus.busy); end
      tick();
    end
    bus.op_valid = 1'b0;
    total++; if (res_seen !== 2) begin bad++; $display("FAIL toggle_res_count got=%0d want=2", res_seen); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL toggle_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    start_run();
    res_seen = 0;
    bus.op_valid = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c == 16) bus.op_valid = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
    total++; if (bus.ph_state !== 8'h00) begin bad++; $display("FAIL mid_ph_state got=%h want=00", bus.ph_state); end
    total++; if (bus.pos_code !== 24'h000000) begin bad++; $display("FAIL mid_pos got=%h want=000000", bus.pos_code); end
    total++; if (bus.neg_code !== 24'hffffff) begin bad++; $display("FAIL mid_neg got=%h want=ffffff", bus.neg_code); end
    tick();
    for (int c = 0; c < 48; c++) begin
      total++; if (bus.pos_code[DAC_W-1:0] !== p0_tab[c % 16]) begin bad++; $display("FAIL restart_p0_code c=%0d got=%0d want=%0d", c, bus.pos_code[DAC_W-1:0], p0_tab[c % 16]); end
      total++; if (bus.ph_state[1:0] !== st_tab[c % 16]) begin bad++; $display("FAIL restart_p0_state c=%0d got=%0d want=%0d", c, bus.ph_state[1:0], st_tab[c % 16]); end
      tick();
    end
    total++; if (res_seen !== 0) begin bad++; $display("FAIL mid_res_count got=%0d want=0", res_seen); end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.op_valid = 1'b0;
    test_reset();
    test_free_run();
    test_launch();
    test_flush_wind();
    test_en_toggle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
